// File: rtl/uart_bus_arbiter_pkg.sv
// Shared types and helpers for the UART slave bus arbiter.
package uart_arb_pkg;

  typedef enum logic [1:0] {IDLE, ADDR, RESP, TOUT} state_t;

  // Response data returned to the owner when the watchdog fires.
  localparam logic [63:0] ERR_DATA = '1;

  function automatic int ptr_w(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/uart_bus_arbiter_if.sv
// A/D channel bundle; N lanes on the requester side, N=1 on the slave side.
interface uart_bus_arbiter_if #(
  parameter int N      = 1,
  parameter int ADDR_W = 4,
  parameter int DATA_W = 32
);
  logic [N-1:0]             a_valid;
  logic [N-1:0]             a_ready;
  logic [N-1:0][ADDR_W-1:0] a_address;
  logic [N-1:0][DATA_W-1:0] a_data;
  logic [N-1:0]             d_valid;
  logic [N-1:0]             d_ready;
  logic [DATA_W-1:0]        d_data;

  modport master (output a_valid, a_address, a_data, d_ready,
                  input  a_ready, d_valid, d_data);
  modport slave  (input  a_valid, a_address, a_data, d_ready,
                  output a_ready, d_valid, d_data);
endinterface

// File: rtl/uart_bus_arbiter_rr_pick.sv
// Combinational round-robin picker: first set req bit at or after ptr, wrapping.
module rr_pick #(
  parameter int NREQ = 2,
  parameter int PW   = 1
) (
  input  logic [NREQ-1:0] req,
  input  logic [PW-1:0]   ptr,
  output logic [NREQ-1:0] gnt,
  output logic [PW-1:0]   idx,
  output logic            any
);
  int off, best;

  // Winner is the requester with the smallest rotated distance from ptr.
  always_comb begin
    gnt  = '0;
    idx  = '0;
    off  = 0;
    best = NREQ;
    for (int j = 0; j < NREQ; j++) begin
      off = (j >= int'(ptr)) ? j - int'(ptr) : j + NREQ - int'(ptr);
      if (req[j] && off < best) begin
        best = off;
        idx  = PW'(j);
      end
    end
    any      = |req;
    gnt[idx] = any;
  end
endmodule

// File: rtl/uart_bus_arbiter.sv
// Round-robin arbiter sharing the UART register slave among NREQ requesters.
// Optional response watchdog enabled by defining UARB_TIMEOUT_EN.
module uart_bus_arbiter
  import uart_arb_pkg::*;
#(
  parameter int NREQ        = 2,
  parameter int ADDR_W      = 4,
  parameter int DATA_W      = 32,
  parameter int TIMEOUT_CYC = 1024
) (
  input  logic             clk,
  input  logic             rst_n,
  uart_bus_arbiter_if.slave  m,
  uart_bus_arbiter_if.master s,
  output logic             timeout_err
);
  localparam int PW = ptr_w(NREQ);

  if (NREQ < 2 || NREQ > 8 || TIMEOUT_CYC < 2) begin : g_bad_cfg
    $error("uart_bus_arbiter: unsupported parameter set");
  end

  state_t            state, state_nxt;
  logic [PW-1:0]     ptr, owner, win_idx;
  logic [NREQ-1:0]   win_gnt;
  logic              win_any, done, tmo;
  logic [ADDR_W-1:0] addr_q;
  logic [DATA_W-1:0] data_q;

  rr_pick #(.NREQ(NREQ), .PW(PW)) u_pick (
    .req(m.a_valid), .ptr(ptr), .gnt(win_gnt), .idx(win_idx), .any(win_any)
  );

  assign s.a_address[0] = addr_q;
  assign s.a_data[0]    = data_q;

`ifdef UARB_TIMEOUT_EN
  localparam int TW = $clog2(TIMEOUT_CYC) + 1;
  logic [TW-1:0] tcnt;

  // Held at zero in IDLE so it starts from 0 on entry to ADDR.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      tcnt        <= '0;
      timeout_err <= 1'b0;
    end else begin
      if (state == IDLE)      tcnt <= '0;
      else if (state != TOUT) tcnt <= tcnt + 1'b1;
      if (state_nxt == TOUT)  timeout_err <= 1'b1;
    end
  end
  assign tmo = (tcnt >= TW'(TIMEOUT_CYC - 1));
`else
  assign tmo         = 1'b0;
  assign timeout_err = 1'b0;
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt  = state;
    m.a_ready  = '0;
    m.d_valid  = '0;
    m.d_data   = '0;
    s.a_valid  = '0;
    s.d_ready  = '0;
    done       = 1'b0;
    case (state)
      IDLE: if (win_any) begin
        m.a_ready = win_gnt;
        state_nxt = ADDR;
      end
      ADDR: begin
        s.a_valid = '1;
        if (s.a_ready[0]) state_nxt = RESP;
        else if (tmo)     state_nxt = TOUT;
      end
      RESP: begin
        m.d_valid[owner] = s.d_valid[0];
        s.d_ready[0]     = m.d_ready[owner];
        m.d_data         = s.d_data;
        if (s.d_valid[0] && m.d_ready[owner]) begin
          done      = 1'b1;
          state_nxt = IDLE;
        end else if (tmo) begin
          state_nxt = TOUT;
        end
      end
`ifdef UARB_TIMEOUT_EN
      // Slave never answered: hand the owner an error word and release the bus.
      TOUT: begin
        m.d_valid[owner] = 1'b1;
        m.d_data         = ERR_DATA[DATA_W-1:0];
        if (m.d_ready[owner]) begin
          done      = 1'b1;
          state_nxt = IDLE;
        end
      end
`endif
      default: state_nxt = IDLE;
    endcase
  end

  // Pointer moves only on completion, so a loser waits at most NREQ-1 transactions.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ptr    <= '0;
      owner  <= '0;
      addr_q <= '0;
      data_q <= '0;
    end else begin
      if (state == IDLE && win_any) begin
        owner  <= win_idx;
        addr_q <= m.a_address[win_idx];
        data_q <= m.a_data[win_idx];
      end
      if (done) ptr <= (owner == PW'(NREQ - 1)) ? '0 : owner + 1'b1;
    end
  end
endmodule
